wstage_commit: RTL and testbench

WSTAGE_COMMIT -- requirements
Module: wstage_commit

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_mux.sv | 30 +++
 rtl/wstage_commit.sv | 121 ++++++++++++
 tb/tb_wstage_commit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: data-source codes, trap CSR addresses and
// the commit-stage state encoding.
package wb_pkg;

    localparam logic [2:0] SRC_ALU  = 3'd0;
    localparam logic [2:0] SRC_MEM  = 3'd1;
    localparam logic [2:0] SRC_SNPC = 3'd2;
    localparam logic [2:0] SRC_CSR  = 3'd3;
    localparam logic [2:0] SRC_CMP  = 3'd4;
    localparam logic [2:0] SRC_NONE = 3'd5;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic {
        IDLE   = 1'b0,
        ECALL2 = 1'b1
    } state_t;

    // Codes 5..7 all mean "no register-file write".
    function automatic logic src_writes_rf(input logic [2:0] src);
        return (src <= SRC_CMP);
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Combinational writeback data select for the commit stage.
module wb_mux
    import wb_pkg::*;
(
    input  logic [2:0]  rdregsrc,
    input  logic [31:0] alu_result,
    input  logic [31:0] mdata,
    input  logic [31:0] snpc,
    input  logic [31:0] csr_old,
    input  logic        cmp_result,
    output logic [31:0] wdata,
    output logic        rf_write,
    output logic        csr_write
);

    always_comb begin
        wdata     = 32'd0;
        rf_write  = src_writes_rf(rdregsrc);
        csr_write = (rdregsrc == SRC_CSR);
        case (rdregsrc)
            SRC_ALU:  wdata = alu_result;
            SRC_MEM:  wdata = mdata;
            SRC_SNPC: wdata = snpc;
            SRC_CSR:  wdata = csr_old;
            SRC_CMP:  wdata = {31'd0, cmp_result};
            default:  wdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/wstage_commit.sv
// Writeback/commit stage: retires one bundle per cycle, splitting ecall into
// an mepc write followed by an mcause write plus trap redirect.
module wstage_commit
    import wb_pkg::*;
#(
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [2:0]  rdregsrcW,
    input  logic [31:0] mdataW,
    input  logic [31:0] ALU_resultW,
    input  logic [31:0] snpcW,
    input  logic [31:0] pcW,
    input  logic [31:0] dnpcW,
    input  logic        cmp_resultW,
    input  logic        ecallW,
    input  logic [31:0] csrW,
    input  logic [11:0] csraddrW,
    input  logic [4:0]  rdW,
    input  logic [31:0] mtvec,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        commit,
    output logic [31:0] commit_pc
);

    state_t      state;
    logic [31:0] saved_pc;
    logic [31:0] mux_wdata;
    logic        mux_rf_write;
    logic        mux_csr_write;

    assign s_ready = (state == IDLE);

    wb_mux u_wb_mux (
        .rdregsrc   (rdregsrcW),
        .alu_result (ALU_resultW),
        .mdata      (mdataW),
        .snpc       (snpcW),
        .csr_old    (csrW),
        .cmp_result (cmp_resultW),
        .wdata      (mux_wdata),
        .rf_write   (mux_rf_write),
        .csr_write  (mux_csr_write)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            saved_pc  <= 32'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            csr_we    <= 1'b0;
            csr_waddr <= 12'd0;
            csr_wdata <= 32'd0;
            pc_we     <= 1'b0;
            pc_next   <= 32'd0;
            commit    <= 1'b0;
            commit_pc <= 32'd0;
        end else begin
            // Every output is a one-cycle pulse; default back to zero.
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            csr_we    <= 1'b0;
            csr_waddr <= 12'd0;
            csr_wdata <= 32'd0;
            pc_we     <= 1'b0;
            pc_next   <= 32'd0;
            commit    <= 1'b0;
            commit_pc <= 32'd0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        if (ecallW) begin
                            csr_we    <= 1'b1;
                            csr_waddr <= CSR_MEPC;
                            csr_wdata <= pcW;
                            saved_pc  <= pcW;
                            state     <= ECALL2;
                        end else begin
                            rf_we     <= mux_rf_write && (rdW != 5'd0);
                            rf_waddr  <= rdW;
                            rf_wdata  <= mux_wdata;
                            if (mux_csr_write) begin
                                csr_we    <= 1'b1;
                                csr_waddr <= csraddrW;
                                csr_wdata <= ALU_resultW;
                            end
                            pc_we     <= 1'b1;
                            pc_next   <= dnpcW;
                            commit    <= 1'b1;
                            commit_pc <= pcW;
                        end
                    end
                end
                ECALL2: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MCAUSE;
                    csr_wdata <= ECALL_CAUSE;
                    pc_we     <= 1'b1;
                    pc_next   <= mtvec;
                    commit    <= 1'b1;
                    commit_pc <= saved_pc;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wstage_commit.sv
// Directed-vector bench for wstage_commit with hand-computed expectations.
module tb_wstage_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  rdregsrcW;
    logic [31:0] mdataW, ALU_resultW, snpcW, pcW, dnpcW, csrW, mtvec;
    logic        cmp_resultW, ecallW;
    logic [11:0] csraddrW;
    logic [4:0]  rdW;
    logic        rf_we, csr_we, pc_we, commit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata, pc_next, commit_pc;
    logic [11:0] csr_waddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wstage_commit #(.ECALL_CAUSE(32'd11)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .rdregsrcW(rdregsrcW), .mdataW(mdataW), .ALU_resultW(ALU_resultW),
        .snpcW(snpcW), .pcW(pcW), .dnpcW(dnpcW), .cmp_resultW(cmp_resultW),
        .ecallW(ecallW), .csrW(csrW), .csraddrW(csraddrW), .rdW(rdW),
        .mtvec(mtvec), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .pc_we(pc_we), .pc_next(pc_next), .commit(commit), .commit_pc(commit_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Fixed relations let each vector stay one line: snpc=pc+4, dnpc=pc+8.
    task automatic set_bundle(input logic [2:0] src, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] pc,
                              input logic ec);
        s_valid     = 1'b1;
        rdregsrcW   = src;
        rdW         = rd;
        ALU_resultW = alu;
        pcW         = pc;
        snpcW       = pc + 32'd4;
        dnpcW       = pc + 32'd8;
        ecallW      = ec;
        mdataW      = 32'hDEAD;
        csrW        = 32'h8;
        csraddrW    = 12'h300;
        cmp_resultW = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, ".csr_we"}, {31'd0, csr_we}, 32'd0);
        chk({tag, ".pc_we"}, {31'd0, pc_we}, 32'd0);
        chk({tag, ".commit"}, {31'd0, commit}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        mtvec = 32'h80000100;
        set_bundle(3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        s_valid = 1'b0;
        step(); step();
        chk_idle("reset");
        chk("reset.s_ready", {31'd0, s_ready}, 32'd1);
        chk("reset.commit_pc", commit_pc, 32'd0);
        rst = 1'b0;

        // ALU writeback
        set_bundle(3'd0, 5'd5, 32'h1234, 32'h100, 1'b0);
        step();
        $display("txn alu: rf_we=%0d waddr=%0d wdata=%h commit=%0d", rf_we, rf_waddr, rf_wdata, commit);
        chk("alu.rf_we", {31'd0, rf_we}, 32'd1);
        chk("alu.waddr", {27'd0, rf_waddr}, 32'd5);
        chk("alu.wdata", rf_wdata, 32'h1234);
        chk("alu.pc_we", {31'd0, pc_we}, 32'd1);
        chk("alu.pc_next", pc_next, 32'h108);
        chk("alu.commit", {31'd0, commit}, 32'd1);
        chk("alu.commit_pc", commit_pc, 32'h100);
        chk("alu.csr_we", {31'd0, csr_we}, 32'd0);
        s_valid = 1'b0;
        step();
        chk_idle("novalid");

        // Load to x0: no register write, still retires
        set_bundle(3'd1, 5'd0, 32'h0, 32'h200, 1'b0);
        step();
        $display("txn mem_x0: rf_we=%0d commit=%0d pc_next=%h", rf_we, commit, pc_next);
        chk("mem0.rf_we", {31'd0, rf_we}, 32'd0);
        chk("mem0.commit", {31'd0, commit}, 32'd1);
        chk("mem0.pc_next", pc_next, 32'h208);

        // Load to x9
        set_bundle(3'd1, 5'd9, 32'h0, 32'h210, 1'b0);
        step();
        $display("txn mem: rf_we=%0d wdata=%h", rf_we, rf_wdata);
        chk("mem.rf_we", {31'd0, rf_we}, 32'd1);
        chk("mem.wdata", rf_wdata, 32'hDEAD);

        // CSR instruction
        set_bundle(3'd3, 5'd3, 32'h88, 32'h300, 1'b0);
        step();
        $display("txn csr: rf_wdata=%h csr_we=%0d csr_waddr=%h csr_wdata=%h", rf_wdata, csr_we, csr_waddr, csr_wdata);
        chk("csr.rf_we", {31'd0, rf_we}, 32'd1);
        chk("csr.rf_wdata", rf_wdata, 32'h8);
        chk("csr.csr_we", {31'd0, csr_we}, 32'd1);
        chk("csr.csr_waddr", {20'd0, csr_waddr}, 32'h300);
        chk("csr.csr_wdata", csr_wdata, 32'h88);

        // snpc (jal link)
        set_bundle(3'd2, 5'd1, 32'h0, 32'h400, 1'b0);
        step();
        $display("txn snpc: rf_wdata=%h", rf_wdata);
        chk("snpc.wdata", rf_wdata, 32'h404);
        chk("snpc.csr_we", {31'd0, csr_we}, 32'd0);

        // compare result, zero-extended
        set_bundle(3'd4, 5'd2, 32'hFFFF, 32'h500, 1'b0);
        step();
        $display("txn cmp: rf_wdata=%h", rf_wdata);
        chk("cmp.wdata", rf_wdata, 32'h1);

        // code 6 behaves as "no write"
        set_bundle(3'd6, 5'd4, 32'h77, 32'h600, 1'b0);
        step();
        $display("txn src6: rf_we=%0d csr_we=%0d commit=%0d", rf_we, csr_we, commit);
        chk("src6.rf_we", {31'd0, rf_we}, 32'd0);
        chk("src6.csr_we", {31'd0, csr_we}, 32'd0);
        chk("src6.commit", {31'd0, commit}, 32'd1);

        // ecall with rdregsrc=CSR: ecall must win
        set_bundle(3'd3, 5'd7, 32'h55, 32'h80000010, 1'b1);
        step();
        $display("txn ecall1: csr_we=%0d addr=%h data=%h s_ready=%0d", csr_we, csr_waddr, csr_wdata, s_ready);
        chk("ec1.csr_we", {31'd0, csr_we}, 32'd1);
        chk("ec1.csr_waddr", {20'd0, csr_waddr}, 32'h341);
        chk("ec1.csr_wdata", csr_wdata, 32'h80000010);
        chk("ec1.rf_we", {31'd0, rf_we}, 32'd0);
        chk("ec1.pc_we", {31'd0, pc_we}, 32'd0);
        chk("ec1.commit", {31'd0, commit}, 32'd0);
        chk("ec1.s_ready", {31'd0, s_ready}, 32'd0);
        // next bundle waits with s_valid high while stalled
        set_bundle(3'd0, 5'd6, 32'hABC, 32'h80000100, 1'b0);
        step();
        $display("txn ecall2: csr_addr=%h data=%h pc_next=%h commit_pc=%h", csr_waddr, csr_wdata, pc_next, commit_pc);
        chk("ec2.csr_we", {31'd0, csr_we}, 32'd1);
        chk("ec2.csr_waddr", {20'd0, csr_waddr}, 32'h342);
        chk("ec2.csr_wdata", csr_wdata, 32'd11);
        chk("ec2.pc_we", {31'd0, pc_we}, 32'd1);
        chk("ec2.pc_next", pc_next, 32'h80000100);
        chk("ec2.commit", {31'd0, commit}, 32'd1);
        chk("ec2.commit_pc", commit_pc, 32'h80000010);
        chk("ec2.rf_we", {31'd0, rf_we}, 32'd0);
        chk("ec2.s_ready", {31'd0, s_ready}, 32'd1);
        mtvec = 32'h12345678;
        step();
        $display("txn after_ecall: commit=%0d commit_pc=%h wdata=%h", commit, commit_pc, rf_wdata);
        chk("post.commit", {31'd0, commit}, 32'd1);
        chk("post.commit_pc", commit_pc, 32'h80000100);
        chk("post.wdata", rf_wdata, 32'hABC);
        chk("post.csr_we", {31'd0, csr_we}, 32'd0);

        // four back-to-back bundles, no bubbles
        for (int i = 0; i < 4; i++) begin
            set_bundle(3'd0, 5'd10, 32'h1000 + i, 32'h700 + 4 * i, 1'b0);
            step();
            $display("txn b2b%0d: commit=%0d commit_pc=%h", i, commit, commit_pc);
            chk($sformatf("b2b%0d.commit", i), {31'd0, commit}, 32'd1);
            chk($sformatf("b2b%0d.commit_pc", i), commit_pc, 32'h700 + 4 * i);
        end

        // reset in the middle of ECALL2
        mtvec = 32'h80000100;
        set_bundle(3'd5, 5'd0, 32'h0, 32'h900, 1'b1);
        step();
        s_valid = 1'b0;
        chk("rst_ec.s_ready_pre", {31'd0, s_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        $display("txn rst_ecall2: csr_we=%0d pc_we=%0d commit=%0d s_ready=%0d", csr_we, pc_we, commit, s_ready);
        chk_idle("rst_async");
        chk("rst_async.csr_wdata", csr_wdata, 32'd0);
        chk("rst_async.s_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk_idle("rst_hold");
        rst = 1'b0;
        step();
        chk_idle("rst_after");
        chk("rst_after.s_ready", {31'd0, s_ready}, 32'd1);

        // handshake on first edge after reset release
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_bundle(3'd0, 5'd8, 32'hBEEF, 32'hA00, 1'b0);
        step();
        $display("txn first_after_rst: commit=%0d wdata=%h", commit, rf_wdata);
        chk("first.commit", {31'd0, commit}, 32'd1);
        chk("first.wdata", rf_wdata, 32'hBEEF);
        s_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
